// File: rtl/video_timing_pkg.sv
// Purpose : shared geometry defaults and the sync-start helper for the video timing generator.
// Latency : none (constants and a pure function).
// Backpressure: none.
package video_timing_pkg;

   // Default arcade geometry: 336x240 visible area in a 456x262 raster.
   localparam int DEF_H_ACTIVE     = 336;
   localparam int DEF_H_TOTAL      = 456;
   localparam int DEF_H_SYNC_START = 360;
   localparam int DEF_H_SYNC_W     = 24;
   localparam int DEF_V_ACTIVE     = 240;
   localparam int DEF_V_TOTAL      = 262;
   localparam int DEF_V_SYNC_START = 240;
   localparam int DEF_V_SYNC_W     = 3;

   // Sync start = nominal + 2*offset, clamped so that the whole pulse still fits
   // before the end of the line/frame. The counters are never touched by the
   // clamp, so line and frame lengths stay fixed.
   function automatic logic [31:0] sync_start(
      input logic [31:0] nominal,
      input logic [31:0] offs,
      input logic [31:0] width,
      input logic [31:0] total
   );
      logic [31:0] shifted;
      logic [31:0] limit;
      shifted = nominal + (offs << 1);
      limit   = total - width;
      return (shifted > limit) ? limit : shifted;
   endfunction

endpackage

// File: rtl/video_axis_counter.sv
// Purpose : one wrapping raster counter (0..TOTAL-1) with enable, terminal-count and blank decode.
// Latency : count updates one clk edge after an enabled cycle; wrap/blank are combinational on the count.
// Backpressure: none; the counter simply holds while en is low.
//
// Ports: clk/reset_n (sync, active low), en (advance), cnt (current count),
//        wrap (cnt is at TOTAL-1, next enabled edge returns to 0), blank (cnt >= ACTIVE).
module video_axis_counter #(
   parameter int TOTAL  = 456,
   parameter int ACTIVE = 336,
   parameter int W      = 9
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         wrap,
   output logic         blank
);

   assign wrap  = (cnt == W'(TOTAL - 1));
   assign blank = (cnt >= W'(ACTIVE));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= wrap ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/video_timing_gen.sv
// Purpose : parametrised raster timing (counters, blanks, active-low syncs, strobes, blank-gated RGB).
// Latency : HPOS/VPOS one clk edge after a ce; registered outputs one ce behind HPOS/VPOS.
// Backpressure: none; everything advances only on ce_pix, outputs hold otherwise (strobes drop to 0).
//
// Ports: clk_sys, RESET_N (sync, active low), ce_pix; HOFFS/VOFFS sync offsets in 2-unit steps;
//        iRGB pixel for current HPOS/VPOS; HPOS/VPOS raster position; oRGB, HBLK, VBLK, HSYN, VSYN,
//        line_start, frame_start registered and mutually aligned.
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int H_ACTIVE     = DEF_H_ACTIVE,
   parameter int H_TOTAL      = DEF_H_TOTAL,
   parameter int H_SYNC_START = DEF_H_SYNC_START,
   parameter int H_SYNC_W     = DEF_H_SYNC_W,
   parameter int V_ACTIVE     = DEF_V_ACTIVE,
   parameter int V_TOTAL      = DEF_V_TOTAL,
   parameter int V_SYNC_START = DEF_V_SYNC_START,
   parameter int V_SYNC_W     = DEF_V_SYNC_W,
   parameter int HOFFS_W      = 5,
   parameter int VOFFS_W      = 3,
   parameter int RGB_W        = 8,
   parameter int POS_W        = 9
) (
   input  logic               clk_sys,
   input  logic               RESET_N,
   input  logic               ce_pix,
   input  logic [HOFFS_W-1:0] HOFFS,
   input  logic [VOFFS_W-1:0] VOFFS,
   input  logic [RGB_W-1:0]   iRGB,
   output logic [POS_W-1:0]   HPOS,
   output logic [POS_W-1:0]   VPOS,
   output logic [RGB_W-1:0]   oRGB,
   output logic               HBLK,
   output logic               VBLK,
   output logic               HSYN,
   output logic               VSYN,
   output logic               line_start,
   output logic               frame_start
);

   // Two guard bits so nominal + 2*offset can never wrap before the clamp.
   localparam int SS_W = POS_W + 2;

   logic [POS_W-1:0]   hcnt;
   logic [POS_W-1:0]   vcnt;
   logic               h_wrap;
   logic               v_wrap;
   logic               hb;
   logic               vb;
   logic               hs;
   logic               vs;
   logic [HOFFS_W-1:0] hoffs_q;
   logic [VOFFS_W-1:0] voffs_q;
   logic [SS_W-1:0]    hs_start;
   logic [SS_W-1:0]    vs_start;
   logic [SS_W-1:0]    hcnt_x;
   logic [SS_W-1:0]    vcnt_x;

   video_axis_counter #(
      .TOTAL  (H_TOTAL),
      .ACTIVE (H_ACTIVE),
      .W      (POS_W)
   ) u_hcnt (
      .clk     (clk_sys),
      .reset_n (RESET_N),
      .en      (ce_pix),
      .cnt     (hcnt),
      .wrap    (h_wrap),
      .blank   (hb)
   );

   video_axis_counter #(
      .TOTAL  (V_TOTAL),
      .ACTIVE (V_ACTIVE),
      .W      (POS_W)
   ) u_vcnt (
      .clk     (clk_sys),
      .reset_n (RESET_N),
      .en      (ce_pix & h_wrap),
      .cnt     (vcnt),
      .wrap    (v_wrap),
      .blank   (vb)
   );

   assign HPOS = hcnt;
   assign VPOS = vcnt;

   // Offsets follow the inputs during reset, then only latch on the last pixel
   // of a frame so a mid-frame change never moves a sync within a frame.
   always_ff @(posedge clk_sys) begin
      if (!RESET_N) begin
         hoffs_q <= HOFFS;
         voffs_q <= VOFFS;
      end else if (ce_pix && h_wrap && v_wrap) begin
         hoffs_q <= HOFFS;
         voffs_q <= VOFFS;
      end
   end

   assign hs_start = SS_W'(sync_start(32'(H_SYNC_START), 32'(hoffs_q), 32'(H_SYNC_W), 32'(H_TOTAL)));
   assign vs_start = SS_W'(sync_start(32'(V_SYNC_START), 32'(voffs_q), 32'(V_SYNC_W), 32'(V_TOTAL)));

   assign hcnt_x = SS_W'(hcnt);
   assign vcnt_x = SS_W'(vcnt);

   assign hs = (hcnt_x >= hs_start) && (hcnt_x < hs_start + SS_W'(H_SYNC_W));
   assign vs = (vcnt_x >= vs_start) && (vcnt_x < vs_start + SS_W'(V_SYNC_W));

   always_ff @(posedge clk_sys) begin
      if (!RESET_N) begin
         oRGB        <= '0;
         HBLK        <= 1'b1;
         VBLK        <= 1'b1;
         HSYN        <= 1'b1;
         VSYN        <= 1'b1;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         // Strobes are re-evaluated every clk so they fall on non-ce cycles.
         line_start  <= ce_pix && (hcnt == '0);
         frame_start <= ce_pix && (hcnt == '0) && (vcnt == '0);
         if (ce_pix) begin
            oRGB <= (hb || vb) ? '0 : iRGB;
            HBLK <= hb;
            VBLK <= vb;
            HSYN <= ~hs;
            VSYN <= ~vs;
         end
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scaled-down raster (32x16, 20x10 visible) so whole frames fit a short run;
// sync starts and offset widths are chosen so the clamp is reachable in both axes.
module tb_video_timing_gen;

   localparam int HA  = 20;
   localparam int HT  = 32;
   localparam int HSS = 22;
   localparam int HSW = 4;
   localparam int VA  = 10;
   localparam int VT  = 16;
   localparam int VSS = 11;
   localparam int VSW = 2;
   localparam int HOW = 3;
   localparam int VOW = 2;
   localparam int RW  = 8;
   localparam int PW  = 5;

   typedef struct packed {
      logic [PW-1:0] hpos;
      logic [PW-1:0] vpos;
      logic [RW-1:0] rgb;
      logic          hblk;
      logic          vblk;
      logic          hsyn;
      logic          vsyn;
      logic          ls;
      logic          fs;
   } obs_t;

   logic           clk_sys = 1'b0;
   logic           RESET_N = 1'b0;
   logic           ce_pix  = 1'b0;
   logic [HOW-1:0] HOFFS   = '0;
   logic [VOW-1:0] VOFFS   = '0;
   logic [RW-1:0]  iRGB    = '0;
   logic [PW-1:0]  HPOS;
   logic [PW-1:0]  VPOS;
   logic [RW-1:0]  oRGB;
   logic           HBLK, VBLK, HSYN, VSYN, line_start, frame_start;

   video_timing_gen #(
      .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_W(HSW),
      .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_W(VSW),
      .HOFFS_W(HOW), .VOFFS_W(VOW), .RGB_W(RW), .POS_W(PW)
   ) dut (
      .clk_sys(clk_sys), .RESET_N(RESET_N), .ce_pix(ce_pix),
      .HOFFS(HOFFS), .VOFFS(VOFFS), .iRGB(iRGB),
      .HPOS(HPOS), .VPOS(VPOS), .oRGB(oRGB),
      .HBLK(HBLK), .VBLK(VBLK), .HSYN(HSYN), .VSYN(VSYN),
      .line_start(line_start), .frame_start(frame_start)
   );

   always #5 clk_sys = ~clk_sys;

   obs_t sb[$];
   obs_t mdl;
   obs_t obs;
   int   hm, vm, hq, vq, pre_h, pre_v;
   bit   rgb_fixed;
   int   n_pass  = 0;
   int   n_total = 0;

   // Drive one clk cycle, push the model's expected outputs, sample the DUT #1 after the edge.
   task automatic step(input logic ce, input logic rst_n);
      obs_t e;
      int   hs0, vs0;
      ce_pix  = ce;
      RESET_N = rst_n;
      iRGB    = rgb_fixed ? RW'(8'hFF) : RW'($urandom);
      pre_h   = hm;
      pre_v   = vm;
      e       = mdl;
      e.ls    = 1'b0;
      e.fs    = 1'b0;
      if (!rst_n) begin
         e  = '{hpos: '0, vpos: '0, rgb: '0, hblk: 1'b1, vblk: 1'b1,
                hsyn: 1'b1, vsyn: 1'b1, ls: 1'b0, fs: 1'b0};
         hm = 0; vm = 0; hq = int'(HOFFS); vq = int'(VOFFS);
      end else if (ce) begin
         hs0 = HSS + 2 * hq; if (hs0 > HT - HSW) hs0 = HT - HSW;
         vs0 = VSS + 2 * vq; if (vs0 > VT - VSW) vs0 = VT - VSW;
         e.hblk = (hm >= HA);
         e.vblk = (vm >= VA);
         e.hsyn = !(hm >= hs0 && hm < hs0 + HSW);
         e.vsyn = !(vm >= vs0 && vm < vs0 + VSW);
         e.rgb  = (e.hblk || e.vblk) ? '0 : iRGB;
         e.ls   = (hm == 0);
         e.fs   = (hm == 0 && vm == 0);
         if (hm == HT - 1 && vm == VT - 1) begin
            hq = int'(HOFFS); vq = int'(VOFFS);
         end
         if (hm == HT - 1) begin
            hm = 0; vm = (vm == VT - 1) ? 0 : vm + 1;
         end else begin
            hm = hm + 1;
         end
         e.hpos = PW'(hm);
         e.vpos = PW'(vm);
      end
      mdl = e;
      sb.push_back(e);
      @(posedge clk_sys);
      #1;
      obs = '{hpos: HPOS, vpos: VPOS, rgb: oRGB, hblk: HBLK, vblk: VBLK,
              hsyn: HSYN, vsyn: VSYN, ls: line_start, fs: frame_start};
   endtask

   task automatic test_reset;
      obs_t e;
      HOFFS = '0; VOFFS = '0; rgb_fixed = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step(i % 4 == 0, 1'b0);
         e = sb.pop_front(); n_total++;
         if (obs !== e) $display("FAIL reset_state cyc %0d: got %h required %h", i, obs, e);
         else n_pass++;
      end
   endtask

   task automatic test_default;
      obs_t e;
      int ces = 0, fs_a = -1, fs_b = -1, hb_first = -1;
      int hmin = 99, hmax = -1, vmin = 99, vmax = -1;
      for (int i = 0; i < 4 * (HT * VT + HT) && fs_b < 0; i++) begin
         step(i % 4 == 0, 1'b1);
         e = sb.pop_front(); n_total++;
         if (obs !== e) $display("FAIL sb_default (%0d,%0d): got %h required %h", pre_h, pre_v, obs, e);
         else n_pass++;
         if (i % 4 == 0) begin
            if (obs.fs) begin
               if (fs_a < 0) fs_a = ces; else fs_b = ces;
            end
            if (pre_v == 0 && obs.hblk && hb_first < 0) hb_first = pre_h;
            if (pre_v == 2 && !obs.hsyn) begin
               if (pre_h < hmin) hmin = pre_h;
               if (pre_h > hmax) hmax = pre_h;
            end
            if (!obs.vsyn) begin
               if (pre_v < vmin) vmin = pre_v;
               if (pre_v > vmax) vmax = pre_v;
            end
            ces++;
         end
      end
      n_total++; if (fs_a != 0 || fs_b - fs_a != HT * VT) $display("FAIL frame_period: got first %0d period %0d required 0 and %0d", fs_a, fs_b - fs_a, HT * VT); else n_pass++;
      n_total++; if (hb_first != HA) $display("FAIL hblk_rise: got hcnt %0d required %0d", hb_first, HA); else n_pass++;
      n_total++; if (hmin != HSS || hmax != HSS + HSW - 1) $display("FAIL hsync_nominal: got %0d..%0d required %0d..%0d", hmin, hmax, HSS, HSS + HSW - 1); else n_pass++;
      n_total++; if (vmin != VSS || vmax != VSS + VSW - 1) $display("FAIL vsync_nominal: got %0d..%0d required %0d..%0d", vmin, vmax, VSS, VSS + VSW - 1); else n_pass++;
   endtask

   // Max offsets push both syncs past the end; they must clamp to HT-HSW / VT-VSW.
   task automatic test_offsets_clamp;
      obs_t e;
      int fs_seen = 0, last_ls = -1, ces = 0, bad_len = 0, lines = 0;
      int hmin = 99, hmax = -1, vmin = 99, vmax = -1;
      HOFFS = 3'd7; VOFFS = 2'd3;
      for (int i = 0; i < 3 * HT * VT && fs_seen < 2; i++) begin
         step(1'b1, 1'b1);
         e = sb.pop_front(); n_total++;
         if (obs !== e) $display("FAIL sb_clamp (%0d,%0d): got %h required %h", pre_h, pre_v, obs, e);
         else n_pass++;
         if (obs.fs) fs_seen++;
         if (fs_seen == 1) begin
            if (obs.ls) begin
               if (last_ls >= 0 && ces - last_ls != HT) bad_len++;
               last_ls = ces; lines++;
            end
            if (!obs.hsyn) begin
               if (pre_h < hmin) hmin = pre_h;
               if (pre_h > hmax) hmax = pre_h;
            end
            if (!obs.vsyn) begin
               if (pre_v < vmin) vmin = pre_v;
               if (pre_v > vmax) vmax = pre_v;
            end
         end
         ces++;
      end
      n_total++; if (hmin != HT - HSW || hmax != HT - 1) $display("FAIL hsync_clamp: got %0d..%0d required %0d..%0d", hmin, hmax, HT - HSW, HT - 1); else n_pass++;
      n_total++; if (vmin != VT - VSW || vmax != VT - 1) $display("FAIL vsync_clamp: got %0d..%0d required %0d..%0d", vmin, vmax, VT - VSW, VT - 1); else n_pass++;
      n_total++; if (bad_len != 0 || lines != VT) $display("FAIL line_length: got %0d bad lines of %0d required 0 of %0d", bad_len, lines, VT); else n_pass++;
   endtask

   // Offset change mid-frame must not move hsync until the next frame.
   task automatic test_midframe_offset;
      obs_t e;
      int p1min = 99, p1max = -1, p2min = 99, p2max = -1, phase = 0;
      HOFFS = '0; VOFFS = '0;
      step(1'b1, 1'b0);
      e = sb.pop_front(); n_total++;
      if (obs !== e) $display("FAIL sb_mid_reset: got %h required %h", obs, e); else n_pass++;
      for (int i = 0; i < 4 * HT * VT && !(hm == 10 && vm == 5); i++) begin
         step(1'($urandom_range(0, 1)), 1'b1);
         e = sb.pop_front(); n_total++;
         if (obs !== e) $display("FAIL sb_mid_pre (%0d,%0d): got %h required %h", pre_h, pre_v, obs, e);
         else n_pass++;
      end
      n_total++; if (hm != 10 || vm != 5) $display("FAIL mid_reach: got (%0d,%0d) required (10,5)", hm, vm); else n_pass++;
      HOFFS = 3'd2;
      for (int i = 0; i < 2 * HT * VT && phase < 2; i++) begin
         step(1'b1, 1'b1);
         e = sb.pop_front(); n_total++;
         if (obs !== e) $display("FAIL sb_mid_post (%0d,%0d): got %h required %h", pre_h, pre_v, obs, e);
         else n_pass++;
         if (obs.fs) phase = 1;
         if (phase == 1 && pre_v == 3) phase = 2;
         if (!obs.hsyn && phase == 0) begin
            if (pre_h < p1min) p1min = pre_h;
            if (pre_h > p1max) p1max = pre_h;
         end
         if (!obs.hsyn && phase == 1) begin
            if (pre_h < p2min) p2min = pre_h;
            if (pre_h > p2max) p2max = pre_h;
         end
      end
      n_total++; if (p1min != HSS || p1max != HSS + HSW - 1) $display("FAIL hsync_same_frame: got %0d..%0d required %0d..%0d", p1min, p1max, HSS, HSS + HSW - 1); else n_pass++;
      n_total++; if (p2min != HSS + 4 || p2max != HSS + 4 + HSW - 1) $display("FAIL hsync_next_frame: got %0d..%0d required %0d..%0d", p2min, p2max, HSS + 4, HSS + 4 + HSW - 1); else n_pass++;
   endtask

   task automatic test_rgb_gate;
      obs_t e;
      int fs_seen = 0, vis = 0, bad = 0;
      logic ce;
      rgb_fixed = 1'b1;
      for (int i = 0; i < 6 * HT * VT && fs_seen < 2; i++) begin
         ce = 1'($urandom_range(0, 1));
         step(ce, 1'b1);
         e = sb.pop_front(); n_total++;
         if (obs !== e) $display("FAIL sb_rgb (%0d,%0d): got %h required %h", pre_h, pre_v, obs, e);
         else n_pass++;
         if (ce && obs.fs) fs_seen++;
         if (ce && fs_seen == 1) begin
            if (obs.rgb == 8'hFF && !obs.hblk && !obs.vblk) vis++;
            if ((obs.hblk || obs.vblk) && obs.rgb != '0) bad++;
         end
      end
      n_total++; if (vis != HA * VA) $display("FAIL rgb_visible: got %0d pixels required %0d", vis, HA * VA); else n_pass++;
      n_total++; if (bad != 0) $display("FAIL rgb_blanked: got %0d nonzero blank pixels required 0", bad); else n_pass++;
      rgb_fixed = 1'b0;
   endtask

   task automatic test_reset_pulse;
      obs_t e;
      for (int i = 0; i < 2 * HT * VT && !(hm == 25 && vm == 12); i++) begin
         step(1'b1, 1'b1);
         e = sb.pop_front(); n_total++;
         if (obs !== e) $display("FAIL sb_pulse_pre (%0d,%0d): got %h required %h", pre_h, pre_v, obs, e);
         else n_pass++;
      end
      n_total++; if (HPOS != 5'd25 || VPOS != 5'd12) $display("FAIL pulse_reach: got (%0d,%0d) required (25,12)", HPOS, VPOS); else n_pass++;
      step(1'b1, 1'b0);
      e = sb.pop_front(); n_total++;
      if (obs !== e) $display("FAIL sb_pulse_rst: got %h required %h", obs, e); else n_pass++;
      n_total++; if (obs.hpos != '0 || obs.vpos != '0 || !obs.hblk || !obs.vsyn) $display("FAIL pulse_state: got pos (%0d,%0d) hblk %b vsyn %b required (0,0) 1 1", obs.hpos, obs.vpos, obs.hblk, obs.vsyn); else n_pass++;
      step(1'b1, 1'b1);
      e = sb.pop_front(); n_total++;
      if (obs !== e) $display("FAIL sb_pulse_first: got %h required %h", obs, e); else n_pass++;
      n_total++; if (!obs.fs || !obs.ls || obs.hpos != 5'd1) $display("FAIL pulse_resume: got fs %b ls %b hpos %0d required 1 1 1", obs.fs, obs.ls, obs.hpos); else n_pass++;
      for (int i = 0; i < 2 * HT; i++) begin
         step(1'b1, 1'b1);
         e = sb.pop_front(); n_total++;
         if (obs !== e) $display("FAIL sb_pulse_post (%0d,%0d): got %h required %h", pre_h, pre_v, obs, e);
         else n_pass++;
      end
   endtask

   initial begin
      hm = 0; vm = 0; hq = 0; vq = 0; rgb_fixed = 1'b0;
      mdl = '{hpos: '0, vpos: '0, rgb: '0, hblk: 1'b1, vblk: 1'b1,
              hsyn: 1'b1, vsyn: 1'b1, ls: 1'b0, fs: 1'b0};
      test_reset();
      test_default();
      test_offsets_clamp();
      test_midframe_offset();
      test_rgb_gate();
      test_reset_pulse();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
